traffic_light_monitor: RTL and testbench



---
 rtl/traffic_light_monitor.sv | 211 +++++++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
// Passive protocol checker for the two-lane traffic-light output interface.
// Decodes the lamp vector {Xa,Va,Da,Xb,Vb,Db} into a phase, then checks
// phase legality, phase order and per-phase dwell time. It also decodes the
// four active-low 7-segment digit codes. Violations raise sticky fault flags.
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   Xa,Va,Da / Xb,Vb,Db   lane A / lane B green, yellow, red lamps
//   segA1,segA0,segB1,segB0  active-low digit codes, bit6..bit0 = a..g
//   clr_fault             synchronous clear of the sticky faults
//   phase, phase_valid    decoded phase (0=AG 1=AY 2=BG 3=BY) and legality
//   dispA, dispB          decoded display values 0..99
//   seg_err, fault_conflict, fault_sequence, fault_timing  sticky faults
//   cycles_done           completed clean AG..BY rotations
//
// Optional feature: define MON_STATS_EN to build the rotation counter.
// Without it, cycles_done is tied to 0.
// All outputs are registered, so they show the inputs sampled at the
// previous rising edge.
module traffic_light_monitor #(
  parameter int GREEN_CYC  = 16,
  parameter int YELLOW_CYC = 4,
  parameter int CNT_W      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Xa,
  input  logic        Va,
  input  logic        Da,
  input  logic        Xb,
  input  logic        Vb,
  input  logic        Db,
  input  logic [6:0]  segA1,
  input  logic [6:0]  segA0,
  input  logic [6:0]  segB1,
  input  logic [6:0]  segB0,
  input  logic        clr_fault,
  output logic [1:0]  phase,
  output logic        phase_valid,
  output logic [6:0]  dispA,
  output logic [6:0]  dispB,
  output logic        seg_err,
  output logic        fault_conflict,
  output logic        fault_sequence,
  output logic        fault_timing,
  output logic [15:0] cycles_done
);

  typedef enum logic [1:0] {PH_AG = 2'd0, PH_AY = 2'd1, PH_BG = 2'd2, PH_BY = 2'd3} phase_e;
  typedef enum logic {WAIT_FIRST, TRACK} state_e;

  state_e             state_q, state_d;
  phase_e             prev_q, prev_d;     // phase currently being timed
  logic [CNT_W-1:0]   dwell_q, dwell_d;
  logic               first_q, first_d;   // prev_q is the first phase seen, so its dwell may be partial
  phase_e             lamp_ph;
  logic               lamp_legal, lamp_idle;
  logic               conflict_evt, seq_evt, tim_evt, seg_evt;
  logic [6:0]         dispA_d, dispB_d;

  // Decode one active-low digit code. Bit 4 flags a valid code. An unknown
  // code decodes as digit 0.
  function automatic logic [4:0] seg_dec(input logic [6:0] s);
    case (s)
      7'b0000001: return 5'h10;
      7'b1001111: return 5'h11;
      7'b0010010: return 5'h12;
      7'b0000110: return 5'h13;
      7'b1001100: return 5'h14;
      7'b0100100: return 5'h15;
      7'b0100000: return 5'h16;
      7'b0001111: return 5'h17;
      7'b0000000: return 5'h18;
      7'b0000100: return 5'h19;
      default:    return 5'h00;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] req_dwell(input phase_e p);
    return (p == PH_AG || p == PH_BG) ? CNT_W'(GREEN_CYC) : CNT_W'(YELLOW_CYC);
  endfunction

  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default first, so no path leaves it unassigned (no latch).
    lamp_ph    = PH_AG;
    lamp_legal = 1'b1;
    lamp_idle  = 1'b0;
    case ({Xa, Va, Da, Xb, Vb, Db})
      6'b100001: lamp_ph = PH_AG;
      6'b010001: lamp_ph = PH_AY;
      6'b001100: lamp_ph = PH_BG;
      6'b001010: lamp_ph = PH_BY;
      6'b000000: begin lamp_legal = 1'b0; lamp_idle = 1'b1; end
      default:   lamp_legal = 1'b0;
    endcase
  end

  always_comb begin
    logic [4:0] a1, a0, b1, b0;
    a1 = seg_dec(segA1);
    a0 = seg_dec(segA0);
    b1 = seg_dec(segB1);
    b0 = seg_dec(segB0);
    seg_evt = ~(a1[4] & a0[4] & b1[4] & b0[4]);
    dispA_d = {3'b000, a1[3:0]} * 7'd10 + {3'b000, a0[3:0]};
    dispB_d = {3'b000, b1[3:0]} * 7'd10 + {3'b000, b0[3:0]};
  end

  // Next-state logic for the sequence and dwell tracker.
  always_comb begin
    state_d      = state_q;
    prev_d       = prev_q;
    dwell_d      = dwell_q;
    first_d      = first_q;
    conflict_evt = 1'b0;
    seq_evt      = 1'b0;
    tim_evt      = 1'b0;
    case (state_q)
      WAIT_FIRST: begin
        if (lamp_legal) begin
          state_d = TRACK;
          prev_d  = lamp_ph;
          dwell_d = CNT_W'(1);
          first_d = 1'b1;
        end else if (!lamp_idle) begin
          conflict_evt = 1'b1;
        end
      end
      TRACK: begin
        if (!lamp_legal) begin
          // Illegal or IDLE vectors are ignored for timing, so the dwell count holds.
          conflict_evt = 1'b1;
        end else if (lamp_ph == prev_q) begin
          if (dwell_q != '1) dwell_d = dwell_q + CNT_W'(1);
        end else begin
          seq_evt = (lamp_ph != phase_e'(prev_q + 2'd1));
          tim_evt = !first_q && (dwell_q != req_dwell(prev_q));
          prev_d  = lamp_ph;
          dwell_d = CNT_W'(1);
          first_d = 1'b0;
        end
      end
      default: state_d = WAIT_FIRST;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; the synchronous reset is checked first, inside the clocked block.
    if (reset) begin
      state_q        <= WAIT_FIRST;
      prev_q         <= PH_AG;
      dwell_q        <= '0;
      first_q        <= 1'b0;
      phase          <= 2'd0;
      phase_valid    <= 1'b0;
      dispA          <= '0;
      dispB          <= '0;
      seg_err        <= 1'b0;
      fault_conflict <= 1'b0;
      fault_sequence <= 1'b0;
      fault_timing   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      dwell_q     <= dwell_d;
      first_q     <= first_d;
      phase_valid <= lamp_legal;
      if (lamp_legal) phase <= lamp_ph;
      dispA       <= dispA_d;
      dispB       <= dispB_d;
      // When a new fault and clr_fault arrive in the same cycle, the new fault wins.
      seg_err        <= seg_evt      | (seg_err        & ~clr_fault);
      fault_conflict <= conflict_evt | (fault_conflict & ~clr_fault);
      fault_sequence <= seq_evt      | (fault_sequence & ~clr_fault);
      fault_timing   <= tim_evt      | (fault_timing   & ~clr_fault);
    end
  end

`ifdef MON_STATS_EN
  logic        rot_ok;   // clean since the last AG entry
  logic [15:0] rot_cnt;
  logic        any_evt, ag_entry, by_to_ag;

  always_comb begin
    any_evt  = conflict_evt | seq_evt | tim_evt | seg_evt;
    ag_entry = lamp_legal && (lamp_ph == PH_AG) &&
               (state_q == WAIT_FIRST || prev_q != PH_AG);
    by_to_ag = (state_q == TRACK) && lamp_legal && (lamp_ph == PH_AG) && (prev_q == PH_BY);
  end

  // A fault raised inside a rotation clears rot_ok. The phase-order check
  // means a clean BY->AG can only follow AY, BG and BY after the AG entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      rot_ok  <= 1'b0;
      rot_cnt <= '0;
    end else begin
      if (by_to_ag && rot_ok && !any_evt && rot_cnt != 16'hFFFF)
        rot_cnt <= rot_cnt + 16'd1;
      if (ag_entry)     rot_ok <= !any_evt;
      else if (any_evt) rot_ok <= 1'b0;
    end
  end

  assign cycles_done = rot_cnt;
`else
  assign cycles_done = 16'd0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed self-checking bench for traffic_light_monitor.
module tb_traffic_light_monitor;

  localparam logic [5:0] L_AG   = 6'b100001;
  localparam logic [5:0] L_AY   = 6'b010001;
  localparam logic [5:0] L_BG   = 6'b001100;
  localparam logic [5:0] L_BY   = 6'b001010;
  localparam logic [5:0] L_IDLE = 6'b000000;
  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                         S9 = 7'b0000100, SBAD = 7'b1111111;

  logic        clk = 1'b0;
  logic        reset, clr_fault;
  logic        Xa, Va, Da, Xb, Vb, Db;
  logic [6:0]  segA1, segA0, segB1, segB0;
  logic [1:0]  phase;
  logic        phase_valid, seg_err, fault_conflict, fault_sequence, fault_timing;
  logic [6:0]  dispA, dispB;
  logic [15:0] cycles_done;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cyc;

  traffic_light_monitor dut (
    .clk(clk), .reset(reset),
    .Xa(Xa), .Va(Va), .Da(Da), .Xb(Xb), .Vb(Vb), .Db(Db),
    .segA1(segA1), .segA0(segA0), .segB1(segB1), .segB0(segB0),
    .clr_fault(clr_fault),
    .phase(phase), .phase_valid(phase_valid),
    .dispA(dispA), .dispB(dispB),
    .seg_err(seg_err), .fault_conflict(fault_conflict),
    .fault_sequence(fault_sequence), .fault_timing(fault_timing),
    .cycles_done(cycles_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply a lamp vector for n cycles; returns 1 ns after the last rising edge.
  task automatic drive(input logic [5:0] l, input int n);
    for (int i = 0; i < n; i++) begin
      {Xa, Va, Da, Xb, Vb, Db} = l;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(L_IDLE, 2);
    reset = 1'b0;
  endtask

  task automatic check_faults(input string tag, input int c, input int s, input int t);
    check({tag, "_conflict"}, int'(fault_conflict), c);
    check({tag, "_sequence"}, int'(fault_sequence), s);
    check({tag, "_timing"},   int'(fault_timing),   t);
  endtask

  initial begin
`ifdef MON_STATS_EN
    exp_cyc = 1;
`else
    exp_cyc = 0;
`endif
    clr_fault = 1'b0;
    segA1 = S0; segA0 = S0; segB1 = S0; segB0 = S0;
    {Xa, Va, Da, Xb, Vb, Db} = L_IDLE;
    #2;

    // Reset state
    do_reset();
    check("rst_phase", int'(phase), 0);
    check("rst_valid", int'(phase_valid), 0);
    check("rst_dispA", int'(dispA), 0);
    check("rst_seg_err", int'(seg_err), 0);
    check("rst_cycles", int'(cycles_done), 0);
    check_faults("rst", 0, 0, 0);

    // Nominal rotation
    drive(L_IDLE, 2);
    check("idle_valid", int'(phase_valid), 0);
    check("idle_conflict", int'(fault_conflict), 0);
    drive(L_AG, 1);
    check("ag_phase", int'(phase), 0);
    check("ag_valid", int'(phase_valid), 1);
    drive(L_AG, 15);
    drive(L_AY, 4);
    check("ay_phase", int'(phase), 1);
    drive(L_BG, 16);
    check("bg_phase", int'(phase), 2);
    drive(L_BY, 4);
    check("by_phase", int'(phase), 3);
    drive(L_AG, 1);
    check("ag2_phase", int'(phase), 0);
    check_faults("nominal", 0, 0, 0);
    check("nominal_cycles", int'(cycles_done), exp_cyc);

    // Conflict in the middle of AG: vector ignored, dwell held
    drive(L_AG, 7);
    drive(6'b100100, 1);
    check("conf_valid", int'(phase_valid), 0);
    check("conf_phase_hold", int'(phase), 0);
    check_faults("conf", 1, 0, 0);
    drive(L_AG, 8);
    drive(L_AY, 1);
    check_faults("conf_after", 1, 0, 0);

    // Clear with no new fault, then clear together with an illegal vector
    clr_fault = 1'b1;
    drive(L_AY, 1);
    check("clr_conflict", int'(fault_conflict), 0);
    drive(6'b111111, 1);
    check("clr_prio_conflict", int'(fault_conflict), 1);
    clr_fault = 1'b0;

    // Skip yellow
    do_reset();
    drive(L_BY, 1);
    drive(L_AG, 16);
    drive(L_BG, 1);
    check_faults("skip", 0, 1, 0);

    // Short green
    do_reset();
    drive(L_BY, 1);
    drive(L_AG, 10);
    drive(L_AY, 1);
    check_faults("short", 0, 0, 1);

    // Reset mid-BG, resume at BG
    do_reset();
    drive(L_BY, 1);
    drive(L_AG, 16);
    drive(L_AY, 4);
    drive(L_BG, 5);
    check_faults("pre_midrst", 0, 0, 0);
    do_reset();
    check("midrst_valid", int'(phase_valid), 0);
    drive(L_BG, 11);
    drive(L_BY, 1);
    check("midrst_phase", int'(phase), 3);
    check_faults("midrst", 0, 0, 0);

    // Segment decode
    segA1 = S2; segA0 = S9;
    drive(L_BY, 1);
    check("dispA_29", int'(dispA), 29);
    check("seg_ok", int'(seg_err), 0);
    segA1 = S9; segB1 = S1; segB0 = SBAD;
    drive(L_BY, 1);
    check("dispA_99", int'(dispA), 99);
    check("dispB_bad_units", int'(dispB), 10);
    check("seg_err_set", int'(seg_err), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed no end of test, expected finish");
    $fatal(1, "timeout");
  end

endmodule
